// File: rtl/fc_mac_stream.sv
// Streaming fully-connected neuron: accumulates N_IN activation*weight pairs,
// adds a bias, applies optional ReLU and saturates into a registered result.
module fc_mac_stream #(
    parameter int N_IN  = 3136,
    parameter int IN_W  = 30,
    parameter int W_W   = 9,
    parameter int B_W   = 9,
    parameter int OUT_W = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic signed [W_W-1:0]   w_data,
    output logic                    in_ready,
    input  logic signed [B_W-1:0]   b,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] output_fc,
    output logic                    done_fc,
    output logic [1:0]              state_dbg
);

    localparam int PROD_W = IN_W + W_W;
    localparam int ACC_W  = PROD_W + $clog2(N_IN) + 1;
    localparam int SUM_W  = ((ACC_W > B_W) ? ACC_W : B_W) + 1;
    localparam int EXT_W  = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  cnt;
    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  sum;
    logic signed [EXT_W-1:0]  relu_sum;
    logic signed [EXT_W-1:0]  sat;
    logic                     accept;

    // Handshake: a pair transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready depends only on state, never on in_valid.
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = enable ? ACCUM : IDLE;
            ACCUM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (in_valid && cnt == LAST_CNT) begin
                    state_nxt = BIAS;
                end
            end
            BIAS:    state_nxt = enable ? DONE : IDLE;
            DONE:    state_nxt = enable ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        done_fc   = (state == DONE);
        state_dbg = state;
    end

    // Operands are sign-extended to the product width so the multiply is exact.
    assign prod = {{W_W{in_data[IN_W-1]}}, in_data} * {{IN_W{w_data[W_W-1]}}, w_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (!enable || state == IDLE) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == ACCUM && accept) begin
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        sum      = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc} + {{(EXT_W-B_W){b[B_W-1]}}, b};
        relu_sum = (relu_en && sum[EXT_W-1]) ? '0 : sum;
        if (relu_sum > MAX_V) begin
            sat = MAX_V;
        end else if (relu_sum < MIN_V) begin
            sat = MIN_V;
        end else begin
            sat = relu_sum;
        end
    end

    // Dropping enable anywhere returns the result to zero along with the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_fc <= '0;
        end else if (!enable) begin
            output_fc <= '0;
        end else if (state == BIAS) begin
            output_fc <= sat[OUT_W-1:0];
        end
    end

endmodule

// File: tb/tb_fc_mac_stream.sv
// Directed and randomized bench for fc_mac_stream using a small integer
// reference model of the neuron (dot product, bias, ReLU, saturation).
module tb_fc_mac_stream;

    localparam int N_IN  = 4;
    localparam int IN_W  = 8;
    localparam int W_W   = 4;
    localparam int B_W   = 4;
    localparam int OUT_W = 12;

    logic                    clk;
    logic                    rst;
    logic                    enable;
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic signed [W_W-1:0]   w_data;
    logic                    in_ready;
    logic signed [B_W-1:0]   b;
    logic                    relu_en;
    logic signed [OUT_W-1:0] output_fc;
    logic                    done_fc;
    logic [1:0]              state_dbg;

    int n_checks = 0;
    int n_err    = 0;

    int in_v[N_IN];
    int w_v[N_IN];
    int b_v;
    bit relu_v;

    fc_mac_stream #(
        .N_IN(N_IN), .IN_W(IN_W), .W_W(W_W), .B_W(B_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .w_data(w_data), .in_ready(in_ready), .b(b),
        .relu_en(relu_en), .output_fc(output_fc), .done_fc(done_fc),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [63:0] out_ext();
        return {{(64-OUT_W){output_fc[OUT_W-1]}}, output_fc};
    endfunction

    // Neuron behaviour from first principles: exact sum, ReLU, clamp.
    function automatic longint model();
        longint s;
        longint hi;
        longint lo;
        s = b_v;
        for (int k = 0; k < N_IN; k++) s += longint'(in_v[k]) * longint'(w_v[k]);
        if (relu_v && s < 0) s = 0;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_idle_out"}, out_ext(), 64'd0);
        check({tag, "_idle_done"}, 64'(done_fc), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd0);
    endtask

    // Full neuron pass starting from IDLE; optional stall of bub_len cycles
    // after pair index bub_after (0-based, -1 for none).
    task automatic run_neuron(input string tag, input int bub_after, input int bub_len);
        logic [63:0] expv;
        expv = 64'(model());
        @(negedge clk);
        enable = 1'b1; in_valid = 1'b0;
        b = B_W'(b_v); relu_en = relu_v;
        @(posedge clk);
        for (int k = 0; k < N_IN; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, "_ready_accum"}, 64'(in_ready), 64'd1);
            check({tag, "_done_early"}, 64'(done_fc), 64'd0);
            in_valid = 1'b1;
            in_data  = IN_W'(in_v[k]);
            w_data   = W_W'(w_v[k]);
            @(posedge clk);
            if (k == bub_after) begin
                for (int j = 0; j < bub_len; j++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = IN_W'($urandom);
                    w_data   = W_W'($urandom);
                    @(posedge clk);
                end
            end
        end
        @(negedge clk);
        check({tag, "_ready_bias"}, 64'(in_ready), 64'd0);
        check({tag, "_done_bias"}, 64'(done_fc), 64'd0);
        in_valid = 1'b1;
        in_data  = IN_W'($urandom);
        w_data   = W_W'($urandom);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done"}, 64'(done_fc), 64'd1);
        check({tag, "_out"}, out_ext(), expv);
        for (int h = 0; h < 2; h++) begin
            in_valid = 1'(h);
            in_data  = IN_W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_done_hold"}, 64'(done_fc), 64'd1);
            check({tag, "_out_hold"}, out_ext(), expv);
            check({tag, "_ready_done"}, 64'(in_ready), 64'd0);
        end
        enable = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle(tag);
    endtask

    // Start a neuron and feed n_pairs pairs, leaving the FSM mid-ACCUM.
    task automatic partial_feed(input int n_pairs);
        @(negedge clk);
        enable = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        for (int k = 0; k < n_pairs; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = IN_W'(100 + k);
            w_data   = W_W'(7);
            @(posedge clk);
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N_IN; k++) begin
            in_v[k] = k + 1;
            w_v[k]  = 1;
        end
        b_v = 2; relu_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0;
        in_data = '0; w_data = '0; b = '0; relu_en = 1'b0;
        #1;
        check_idle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        set_ramp();
        run_neuron("ramp", -1, 0);

        for (int k = 0; k < N_IN; k++) begin in_v[k] = -3; w_v[k] = 2; end
        b_v = 1; relu_v = 1'b0;
        run_neuron("neg", -1, 0);
        relu_v = 1'b1;
        run_neuron("neg_relu", -1, 0);

        for (int k = 0; k < N_IN; k++) begin in_v[k] = 127; w_v[k] = 7; end
        b_v = 7; relu_v = 1'b0;
        run_neuron("sat_hi", -1, 0);
        for (int k = 0; k < N_IN; k++) in_v[k] = -128;
        run_neuron("sat_lo", -1, 0);

        set_ramp();
        run_neuron("bubble", 1, 2);

        partial_feed(2);
        @(negedge clk);
        enable = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("abort");
        set_ramp();
        run_neuron("after_abort", -1, 0);

        partial_feed(2);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst_accum");
        @(negedge clk);
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);
        check_idle("rst_release");
        set_ramp();
        run_neuron("after_rst", -1, 0);

        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < N_IN; k++) begin
                in_v[k] = int'($urandom_range(0, 255)) - 128;
                w_v[k]  = int'($urandom_range(0, 15)) - 8;
            end
            b_v    = int'($urandom_range(0, 15)) - 8;
            relu_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                run_neuron("rand_bub", int'($urandom_range(0, N_IN - 2)), int'($urandom_range(1, 3)));
            else
                run_neuron("rand", -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
